// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit between the PC register and decode.
// Presents the current PC to instruction memory over a req/gnt/rvalid
// handshake with at most one request outstanding, buffers {addr, instr}
// pairs in a small prefetch FIFO and hands them to decode via valid/ready.
// A taken JUMP flushes the FIFO and drops any response still in flight.
//
// Optional build macro: FETCH_MISALIGN_CHK_EN
//   defined     -> extra output FETCH_ERR; a misaligned PC blocks fetching
//                  and raises a sticky error until the next JUMP or reset.
//   not defined -> the low two PC bits are silently masked in IMEM_ADDR.
//
// state | meaning
// IDLE  | first cycle after reset release, nothing issued
// REQ   | presenting a request while a FIFO slot is free
// WAIT  | request granted, waiting for read data (or dropping it)
// STALL | FIFO full, waiting for decode to pop an entry
module instr_fetch #(
    parameter logic [31:0] BOOT_ADDR  = 32'h1A00_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RES_N,
    input  logic [31:0] PC_IN,
    output logic        PC_ENABLE,
    input  logic        JUMP,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    output logic        INSTR_VALID,
    input  logic        INSTR_READY,
    output logic [31:0] INSTR_DATA,
    output logic [31:0] INSTR_ADDR
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        FETCH_ERR
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_STALL = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              discard_q;
    logic              discard_d;
    logic [31:0]       req_addr_q;

    logic [31:0]       fifo_addr [FIFO_DEPTH];
    logic [31:0]       fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_after_push;

    logic              push;
    logic              pop;
    logic              flush;
    logic              latch_addr;
    logic              has_space;
    logic              req_blocked;

    // Word-aligned fetch address; the low bits never reach memory.
    assign IMEM_ADDR = PC_IN & 32'hFFFF_FFFC;

    assign INSTR_VALID = (count_q != '0);
    assign INSTR_DATA  = fifo_data[rd_ptr_q];
    assign INSTR_ADDR  = fifo_addr[rd_ptr_q];

    // A jump outranks the decode handshake, so no pop happens in a jump cycle.
    assign pop = INSTR_VALID & INSTR_READY & ~JUMP;

    // Only issued from REQ, where nothing is outstanding, so occupancy alone decides.
    assign has_space = (count_q < DEPTH_C);

    // Occupancy once the incoming word lands, net of a same-cycle pop.
    assign count_after_push = count_q + CNT_W'(1) - CNT_W'(pop);

`ifdef FETCH_MISALIGN_CHK_EN
    logic fetch_err_q;
    logic misaligned;

    assign misaligned  = (PC_IN[1:0] != 2'b00);
    assign req_blocked = fetch_err_q | misaligned;
    assign FETCH_ERR   = fetch_err_q;

    // Sticky misalignment error: raised by a blocked fetch attempt, cleared by a jump.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            fetch_err_q <= 1'b0;
        end else if (JUMP) begin
            fetch_err_q <= 1'b0;
        end else if ((state_q == S_REQ) && misaligned) begin
            fetch_err_q <= 1'b1;
        end
    end
`else
    assign req_blocked = 1'b0;
`endif

    // Next-state and handshake outputs; JUMP is checked first in every state.
    always_comb begin
        state_d    = state_q;
        discard_d  = discard_q;
        IMEM_REQ   = 1'b0;
        PC_ENABLE  = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        latch_addr = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (JUMP) begin
                    PC_ENABLE = 1'b1;
                    flush     = 1'b1;
                end
            end

            S_REQ: begin
                if (JUMP) begin
                    PC_ENABLE = 1'b1;
                    flush     = 1'b1;
                end else if (req_blocked) begin
                    state_d = S_REQ;
                end else if (has_space) begin
                    IMEM_REQ = 1'b1;
                    if (IMEM_GNT) begin
                        PC_ENABLE  = 1'b1;
                        latch_addr = 1'b1;
                        state_d    = S_WAIT;
                    end
                end else begin
                    state_d = S_STALL;
                end
            end

            S_WAIT: begin
                if (JUMP) begin
                    PC_ENABLE = 1'b1;
                    flush     = 1'b1;
                    if (IMEM_RVALID) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (IMEM_RVALID) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        push    = 1'b1;
                        state_d = (count_after_push < DEPTH_C) ? S_REQ : S_STALL;
                    end
                end
            end

            S_STALL: begin
                if (JUMP) begin
                    PC_ENABLE = 1'b1;
                    flush     = 1'b1;
                    state_d   = S_REQ;
                end else if (pop) begin
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register, discard flag and the address of the granted request.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q    <= S_IDLE;
            discard_q  <= 1'b0;
            req_addr_q <= BOOT_ADDR;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            if (latch_addr) begin
                req_addr_q <= IMEM_ADDR;
            end
        end
    end

    // Prefetch FIFO: pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr[i] <= '0;
                fifo_data[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_addr[wr_ptr_q] <= req_addr_q;
                fifo_data[wr_ptr_q] <= IMEM_RDATA;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch.
// Models the PC register and instruction memory around the DUT, and predicts
// the decode stream as "consecutive word addresses from boot, restarting at
// every jump target", with data a fixed function of the address.
module tb_instr_fetch;

    localparam logic [31:0] BOOT  = 32'h1A00_0000;
    localparam int          DEPTH = 2;

    logic        CLK   = 1'b0;
    logic        RES_N = 1'b1;
    logic [31:0] PC_IN = BOOT;
    logic        PC_ENABLE;
    logic        JUMP = 1'b0;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT = 1'b0;
    logic        IMEM_RVALID = 1'b0;
    logic [31:0] IMEM_RDATA = '0;
    logic        INSTR_VALID;
    logic        INSTR_READY = 1'b0;
    logic [31:0] INSTR_DATA;
    logic [31:0] INSTR_ADDR;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        FETCH_ERR;
`endif

    always #5 CLK = ~CLK;

    instr_fetch #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RES_N      (RES_N),
        .PC_IN      (PC_IN),
        .PC_ENABLE  (PC_ENABLE),
        .JUMP       (JUMP),
        .IMEM_REQ   (IMEM_REQ),
        .IMEM_ADDR  (IMEM_ADDR),
        .IMEM_GNT   (IMEM_GNT),
        .IMEM_RVALID(IMEM_RVALID),
        .IMEM_RDATA (IMEM_RDATA),
        .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY),
        .INSTR_DATA (INSTR_DATA),
        .INSTR_ADDR (INSTR_ADDR)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .FETCH_ERR  (FETCH_ERR)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // environment / reference model state
    logic [31:0] pc_m, exp_head, pend_addr, force_target, last_pop;
    int          cnt_m, pend_dly;
    bit          pend, pend_stale, force_jump, stray_rv;
    int          gnt_pct, ready_pct, jump_pct, rv_min, rv_max;
    int          step_idx, gnt_cnt, pcen_cnt, pop_cnt, first_gnt, first_val;
    logic        s_req, s_pcen, s_val;
    logic [31:0] s_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RES_N       = 1'b0;
        JUMP        = 1'b0;
        IMEM_GNT    = 1'b0;
        IMEM_RVALID = 1'b0;
        INSTR_READY = 1'b0;
        pc_m        = BOOT;
        PC_IN       = BOOT;
        exp_head    = BOOT;
        cnt_m       = 0;
        pend        = 1'b0;
        pend_stale  = 1'b0;
        pend_dly    = 0;
        force_jump  = 1'b0;
        stray_rv    = 1'b0;
        step_idx    = 0;
        gnt_cnt     = 0;
        pcen_cnt    = 0;
        pop_cnt     = 0;
        first_gnt   = -1;
        first_val   = -1;
        last_pop    = '0;
        jump_pct    = 0;
        #1;
        check("rst_imem_req", IMEM_REQ, 0);
        check("rst_pc_enable", PC_ENABLE, 0);
        check("rst_instr_valid", INSTR_VALID, 0);
        check("rst_instr_data", INSTR_DATA, 0);
        check("rst_instr_addr", INSTR_ADDR, 0);
        check("rst_imem_addr", IMEM_ADDR, BOOT);
`ifdef FETCH_MISALIGN_CHK_EN
        check("rst_fetch_err", FETCH_ERR, 0);
`endif
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RES_N = 1'b1;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step();
        logic        jmp, gnt, rv, rv_stale, pop, req_s, pcen_s, val_s;
        logic [31:0] addr_s, ia_s, id_s, tgt, r;
        @(negedge CLK);
        jmp = force_jump;
        tgt = force_target;
        if (!jmp && jump_pct != 0 && $urandom_range(99) < jump_pct) begin
            r = $urandom;
            r[1:0] = 2'b00;
            tgt = r;
            jmp = 1'b1;
        end
        force_jump  = 1'b0;
        JUMP        = jmp;
        rv          = pend && (pend_dly == 0);
        rv_stale    = pend_stale;
        IMEM_RVALID = rv || stray_rv;
        IMEM_RDATA  = rv ? mem_word(pend_addr) : $urandom;
        stray_rv    = 1'b0;
        INSTR_READY = ($urandom_range(99) < ready_pct);
        IMEM_GNT    = 1'b0;
        #1;
        req_s  = IMEM_REQ;
        addr_s = IMEM_ADDR;
        gnt    = req_s && ($urandom_range(99) < gnt_pct);
        IMEM_GNT = gnt;
        #1;
        pcen_s = PC_ENABLE;
        val_s  = INSTR_VALID;
        ia_s   = INSTR_ADDR;
        id_s   = INSTR_DATA;
        pop    = val_s && INSTR_READY && !jmp;

        if (jmp) check("req_during_jump", req_s, 0);
        if (req_s) begin
            check("imem_addr", addr_s, pc_m & 32'hFFFF_FFFC);
            check("one_outstanding", pend, 0);
            check("req_space", cnt_m < DEPTH, 1);
        end
        check("pc_enable", pcen_s, jmp | gnt);
        check("instr_valid", val_s, cnt_m != 0);
        if (val_s) begin
            check("instr_addr", ia_s, exp_head);
            check("instr_data", id_s, mem_word(exp_head));
        end
        if (gnt && first_gnt < 0) first_gnt = step_idx;
        if (val_s && first_val < 0) first_val = step_idx;
        s_req  = req_s;
        s_addr = addr_s;
        s_pcen = pcen_s;
        s_val  = val_s;

        @(posedge CLK);
        #1;
        if (pcen_s) begin
            pc_m = jmp ? tgt : pc_m + 32'd4;
            pcen_cnt++;
        end
        PC_IN = pc_m;
        if (rv) pend = 1'b0;
        if (jmp) begin
            cnt_m    = 0;
            exp_head = tgt;
            if (pend) pend_stale = 1'b1;
        end else begin
            if (rv && !rv_stale) cnt_m++;
            if (pop) begin
                cnt_m--;
                exp_head = exp_head + 32'd4;
                pop_cnt++;
                last_pop = ia_s;
            end
        end
        if (gnt) begin
            pend       = 1'b1;
            pend_addr  = addr_s;
            pend_stale = 1'b0;
            pend_dly   = $urandom_range(rv_max, rv_min);
            gnt_cnt++;
        end else if (pend && pend_dly > 0) begin
            pend_dly--;
        end
        step_idx++;
    endtask

    task automatic set_mode(input int g, input int rd, input int lo, input int hi);
        gnt_pct   = g;
        ready_pct = rd;
        rv_min    = lo;
        rv_max    = hi;
    endtask

    initial begin
        int p0;

        // 1: first fetch after reset, GNT at once, RVALID next cycle
        do_reset();
        set_mode(100, 0, 0, 0);
        step();
        check("t1_first_req", s_req, 1);
        check("t1_first_addr", s_addr, BOOT);
        step();
        check("t1_pcen_pulses", pcen_cnt, 1);
        step();
        check("t1_valid", s_val, 1);
        check("t1_latency", first_val - first_gnt, 2);

        // 2: decode not ready -> exactly DEPTH words fetched, then idle until a pop
        do_reset();
        set_mode(100, 0, 0, 0);
        repeat (12) step();
        check("t2_grants", gnt_cnt, DEPTH);
        check("t2_req_idle", s_req, 0);
        check("t2_pcen_idle", s_pcen, 0);
        check("t2_pcen_total", pcen_cnt, DEPTH);
        ready_pct = 100;
        step();
        ready_pct = 0;
        repeat (4) step();
        check("t2_resume", gnt_cnt, DEPTH + 1);

        // 3: streaming 100 words with decode always ready
        do_reset();
        set_mode(100, 100, 0, 0);
        for (int i = 0; i < 400 && pop_cnt < 100; i++) step();
        check("t3_pop_count", pop_cnt, 100);
        check("t3_last_addr", last_pop, 32'h1A00_018C);

        // 4: jump while a request is outstanding
        do_reset();
        set_mode(100, 0, 0, 0);
        step();
        step();
        rv_min = 3;
        rv_max = 3;
        step();
        force_jump   = 1'b1;
        force_target = 32'hF1E2_A960;
        step();
        step();
        check("t4_flushed", s_val, 0);
        rv_min = 0;
        rv_max = 0;
        for (int i = 0; i < 10 && !s_req; i++) step();
        check("t4_req_after_jump", s_req, 1);
        check("t4_req_addr", s_addr, 32'hF1E2_A960);
        ready_pct = 100;
        p0 = pop_cnt;
        for (int i = 0; i < 10 && pop_cnt == p0; i++) step();
        check("t4_first_pop_addr", last_pop, 32'hF1E2_A960);

        // 5: grant withheld, then reset asserted mid-WAIT
        do_reset();
        set_mode(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t5_req_held", s_req, 1);
            check("t5_addr_stable", s_addr, BOOT);
            check("t5_no_pcen", s_pcen, 0);
        end
        gnt_pct = 100;
        step();
        step();
        rv_min = 4;
        rv_max = 4;
        step();
        step();
        @(negedge CLK);
        #2;
        RES_N = 1'b0;
        #1;
        check("t5_async_req", IMEM_REQ, 0);
        check("t5_async_pcen", PC_ENABLE, 0);
        check("t5_async_valid", INSTR_VALID, 0);
        check("t5_async_data", INSTR_DATA, 0);
        check("t5_async_addr", INSTR_ADDR, 0);
        do_reset();
        set_mode(100, 100, 0, 0);
        stray_rv = 1'b1;
        repeat (8) step();
        check("t5_after_stray", last_pop, BOOT + 32'd4 * (pop_cnt - 1));

`ifdef FETCH_MISALIGN_CHK_EN
        // 6: misaligned PC blocks fetching until a jump
        do_reset();
        set_mode(100, 0, 0, 0);
        pc_m  = BOOT + 32'd2;
        PC_IN = pc_m;
        step();
        check("t6_err_set", FETCH_ERR, 1);
        check("t6_no_req", s_req, 0);
        step();
        check("t6_err_sticky", FETCH_ERR, 1);
        force_jump   = 1'b1;
        force_target = 32'h1A00_0100;
        step();
        check("t6_err_clear", FETCH_ERR, 0);
        step();
        check("t6_resume_req", s_req, 1);
        check("t6_resume_addr", s_addr, 32'h1A00_0100);
`endif

        // random traffic with jumps and variable memory latency
        do_reset();
        set_mode(60, 60, 0, 3);
        jump_pct = 4;
        for (int i = 0; i < 3000; i++) step();
        check("rand_progress", pop_cnt > 100, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
